// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encodings shared by the shift register and its bench
//
// Purpose: single home for the 2-bit operation-select encodings.
// Ports:   none (package).
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_word_counter.sv
// rtl/shift_word_counter.sv - saturating shift counter with one-shot word_done pulse
//
// Purpose: counts shift steps since the last clear/reset, saturating at WIDTH,
//          and pulses done for one cycle when the count first reaches WIDTH.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   clear - restart the word (count to 0, suppress done); wins over step
//   step  - one shift occurred this cycle
//   count - shifts so far, saturating at WIDTH
//   done  - high for the cycle after the count moves WIDTH-1 -> WIDTH
module shift_word_counter #(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          done
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // Once saturated the count never moves again until a clear, so done can
    // only fire on the single WIDTH-1 -> WIDTH transition.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (step && (cnt_q != CNT_MAX)) begin
            cnt_d  = cnt_q + CW'(1);
            done_d = (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign count = cnt_q;
    assign done  = done_q;

endmodule

// File: rtl/param_shift_register.sv
// rtl/param_shift_register.sv - parameterised universal shift register with word tracking
//
// Purpose: HOLD / shift-right / shift-left / parallel-load register with
//          registered serial outputs and a per-word shift counter.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   en        - operation enable; when low the block holds
//   mode      - HOLD=00, SHR=01, SHL=10, LOAD=11
//   ser_in_r  - serial input entering at MSB on SHR
//   ser_in_l  - serial input entering at LSB on SHL
//   par_in    - parallel load data
//   par_out   - register contents (direct flop output)
//   ser_out_r - bit that left the LSB on the most recent SHR
//   ser_out_l - bit that left the MSB on the most recent SHL
//   shift_cnt - shifts since last LOAD/reset, saturating at WIDTH
//   word_done - one-cycle pulse when shift_cnt reaches WIDTH
module param_shift_register
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         ser_in_r,
    input  logic                         ser_in_l,
    input  logic [WIDTH-1:0]             par_in,
    output logic [WIDTH-1:0]             par_out,
    output logic                         ser_out_r,
    output logic                         ser_out_l,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         word_done
);

    logic [WIDTH-1:0] q_q;
    logic             ser_r_q;
    logic             ser_l_q;
    logic             do_shift;
    logic             do_load;

    assign do_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
    assign do_load  = en && (mode == MODE_LOAD);

    // Serial outputs are registered copies of the outgoing bit, which adds one
    // edge after the bit reaches the end of the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= RESET_VAL;
            ser_r_q <= 1'b0;
            ser_l_q <= 1'b0;
        end else if (en) begin
            case (mode)
                MODE_SHR: begin
                    q_q     <= {ser_in_r, q_q[WIDTH-1:1]};
                    ser_r_q <= q_q[0];
                end
                MODE_SHL: begin
                    q_q     <= {q_q[WIDTH-2:0], ser_in_l};
                    ser_l_q <= q_q[WIDTH-1];
                end
                MODE_LOAD: begin
                    q_q <= par_in;
                end
                default: begin
                end
            endcase
        end
    end

    shift_word_counter #(
        .WIDTH (WIDTH)
    ) u_word_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (do_load),
        .step  (do_shift),
        .count (shift_cnt),
        .done  (word_done)
    );

    assign par_out   = q_q;
    assign ser_out_r = ser_r_q;
    assign ser_out_l = ser_l_q;

endmodule

// File: tb/tb_param_shift_register.sv
// tb/tb_param_shift_register.sv - directed self-checking bench for param_shift_register
module tb_param_shift_register;
    import shift_reg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rst8, en8, sr8, sl8;
    logic [1:0] mode8;
    logic [7:0] pin8, pout8;
    logic       sor8, sol8, done8;
    logic [3:0] cnt8;

    logic       rst4, en4, sr4, sl4;
    logic [1:0] mode4;
    logic [3:0] pin4, pout4;
    logic       sor4, sol4, done4;
    logic [2:0] cnt4;

    param_shift_register #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .mode(mode8),
        .ser_in_r(sr8), .ser_in_l(sl8), .par_in(pin8),
        .par_out(pout8), .ser_out_r(sor8), .ser_out_l(sol8),
        .shift_cnt(cnt8), .word_done(done8)
    );

    param_shift_register #(.WIDTH(4), .RESET_VAL(4'h6)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .mode(mode4),
        .ser_in_r(sr4), .ser_in_l(sl4), .par_in(pin4),
        .par_out(pout4), .ser_out_r(sor4), .ser_out_l(sol4),
        .shift_cnt(cnt4), .word_done(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; en8 = 1'b1; mode8 = MODE_LOAD; pin8 = 8'hFF; sr8 = 1'b1; sl8 = 1'b1;
        tick();
        tick();
        n_checks++;
        if (pout8 !== 8'h00) begin n_fail++; $display("FAIL reset_par_out got %h exp 00", pout8); end
        n_checks++;
        if ({sor8, sol8, done8} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {sor8, sol8, done8}); end
        n_checks++;
        if (cnt8 !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", cnt8); end
        rst8 = 1'b0; mode8 = MODE_HOLD;
    endtask

    task automatic test_load_shift();
        logic [7:0] src;
        int pulses;
        src = 8'hA5;
        pulses = 0;
        en8 = 1'b1; mode8 = MODE_LOAD; pin8 = src;
        tick();
        n_checks++;
        if (pout8 !== 8'hA5 || cnt8 !== 4'd0) begin n_fail++; $display("FAIL load_a5 got %h/%0d exp a5/0", pout8, cnt8); end
        mode8 = MODE_SHR; sr8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (sor8 !== src[k]) begin n_fail++; $display("FAIL shr_bit%0d got %b exp %b", k, sor8, src[k]); end
            n_checks++;
            if (done8 !== (k == 7)) begin n_fail++; $display("FAIL shr_done%0d got %b exp %b", k, done8, (k == 7)); end
            if (done8 === 1'b1) pulses++;
        end
        mode8 = MODE_HOLD;
        tick();
        if (done8 === 1'b1) pulses++;
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL shr_pulses got %0d exp 1", pulses); end
        n_checks++;
        if (pout8 !== 8'h00 || cnt8 !== 4'd8) begin n_fail++; $display("FAIL shr_final got %h/%0d exp 00/8", pout8, cnt8); end
    endtask

    task automatic test_shl_enable();
        logic [3:0] en_seq;
        en_seq = 4'b1101;
        en8 = 1'b1; mode8 = MODE_LOAD; pin8 = 8'h81;
        tick();
        mode8 = MODE_SHL; sl8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            en8 = en_seq[k];
            tick();
            if (k == 0) begin
                n_checks++;
                if (sol8 !== 1'b1 || pout8 !== 8'h03) begin n_fail++; $display("FAIL shl_first got %b/%h exp 1/03", sol8, pout8); end
            end
            if (k == 1) begin
                n_checks++;
                if (pout8 !== 8'h03 || cnt8 !== 4'd1) begin n_fail++; $display("FAIL shl_en_off got %h/%0d exp 03/1", pout8, cnt8); end
            end
        end
        n_checks++;
        if (pout8 !== 8'h0F || cnt8 !== 4'd3) begin n_fail++; $display("FAIL shl_final got %h/%0d exp 0f/3", pout8, cnt8); end
        n_checks++;
        if (sol8 !== 1'b0 || sor8 !== 1'b1) begin n_fail++; $display("FAIL shl_serouts got %b%b exp 01", sol8, sor8); end
        en8 = 1'b1; mode8 = MODE_HOLD;
    endtask

    task automatic test_collision();
        mode8 = MODE_LOAD; pin8 = 8'h00;
        tick();
        mode8 = MODE_SHR; sr8 = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        n_checks++;
        if (cnt8 !== 4'd7) begin n_fail++; $display("FAIL coll_pre_cnt got %0d exp 7", cnt8); end
        mode8 = MODE_LOAD; pin8 = 8'h3C;
        tick();
        n_checks++;
        if (done8 !== 1'b0 || cnt8 !== 4'd0 || pout8 !== 8'h3C) begin
            n_fail++; $display("FAIL collision got %b/%0d/%h exp 0/0/3c", done8, cnt8, pout8);
        end
        mode8 = MODE_HOLD;
        tick();
        n_checks++;
        if (done8 !== 1'b0) begin n_fail++; $display("FAIL coll_after got %b exp 0", done8); end
    endtask

    task automatic test_reset_mid_word();
        mode8 = MODE_SHR; sr8 = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (cnt8 !== 4'd5 || sor8 !== 1'b1 || pout8 !== 8'hF9) begin
            n_fail++; $display("FAIL mid_pre got %0d/%b/%h exp 5/1/f9", cnt8, sor8, pout8);
        end
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        n_checks++;
        if (pout8 !== 8'h00 || {sor8, sol8, done8} !== 3'b000 || cnt8 !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset got %h/%b/%0d exp 00/000/0", pout8, {sor8, sol8, done8}, cnt8);
        end
        sr8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (done8 !== (k == 7)) begin n_fail++; $display("FAIL mid_done%0d got %b exp %b", k, done8, (k == 7)); end
        end
    endtask

    task automatic test_saturation();
        int expc;
        mode8 = MODE_LOAD; pin8 = 8'h5A;
        tick();
        mode8 = MODE_SHR; sr8 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 10) mode8 = MODE_SHL;
            tick();
            expc = (k + 1 > 8) ? 8 : k + 1;
            n_checks++;
            if (cnt8 !== 4'(expc) || done8 !== (k == 7)) begin
                n_fail++; $display("FAIL sat%0d got %0d/%b exp %0d/%b", k, cnt8, done8, expc, (k == 7));
            end
        end
    endtask

    task automatic test_siso_w4();
        logic [3:0] stream;
        stream = 4'b1101;
        rst4 = 1'b1; en4 = 1'b0; mode4 = MODE_HOLD; sr4 = 1'b0; sl4 = 1'b0; pin4 = 4'h0;
        tick();
        rst4 = 1'b0;
        n_checks++;
        if (pout4 !== 4'h6 || cnt4 !== 3'd0) begin n_fail++; $display("FAIL w4_reset got %h/%0d exp 6/0", pout4, cnt4); end
        en4 = 1'b1; mode4 = MODE_SHR;
        for (int e = 1; e <= 8; e++) begin
            sr4 = (e <= 4) ? stream[e-1] : 1'b0;
            tick();
            if (e == 1) begin
                n_checks++;
                if (pout4 !== 4'hB) begin n_fail++; $display("FAIL w4_first_op got %h exp b", pout4); end
            end
            if (e >= 5) begin
                n_checks++;
                if (sor4 !== stream[e-5]) begin n_fail++; $display("FAIL w4_siso_e%0d got %b exp %b", e, sor4, stream[e-5]); end
            end
            if (e == 4) begin
                n_checks++;
                if (done4 !== 1'b1) begin n_fail++; $display("FAIL w4_done got %b exp 1", done4); end
            end
        end
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0; mode4 = MODE_SHL;
        for (int e = 1; e <= 5; e++) begin
            sl4 = (e == 1);
            tick();
            if (e >= 4) begin
                n_checks++;
                if (sol4 !== (e == 5)) begin n_fail++; $display("FAIL w4_shl_e%0d got %b exp %b", e, sol4, (e == 5)); end
            end
        end
    endtask

    initial begin
        rst8 = 1'b1; en8 = 1'b0; mode8 = MODE_HOLD; sr8 = 1'b0; sl8 = 1'b0; pin8 = 8'h00;
        rst4 = 1'b1; en4 = 1'b0; mode4 = MODE_HOLD; sr4 = 1'b0; sl4 = 1'b0; pin4 = 4'h0;
        test_reset();
        test_load_shift();
        test_shl_enable();
        test_collision();
        test_reset_mid_word();
        test_saturation();
        test_siso_w4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_shift_register.md
PARAM_SHIFT_REGISTER -- requirements
Module: param_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register length in bits; legal range 2..64.
REQ-002 The block SHALL have parameter RESET_VAL, default all zeros, meaning the value loaded into the register on reset.
REQ-003 clk  input  1  meaning sole clock; all state updates on rising edge.
REQ-004 rst  input  1  meaning reset, synchronous, active-high.
REQ-005 en  input  1  meaning operation enable; when 0, mode is ignored and the block holds.
REQ-006 mode  input  2  meaning operation select: HOLD=00, SHR=01, SHL=10, LOAD=11.
REQ-007 ser_in_r  input  1  meaning serial input entering at MSB during SHR.
REQ-008 ser_in_l  input  1  meaning serial input entering at LSB during SHL.
REQ-009 par_in  input  WIDTH  meaning parallel load data.
REQ-010 par_out  output  WIDTH  meaning current register contents.
REQ-011 ser_out_r  output  1  meaning bit shifted out at LSB; registered copy of q[0] taken before the SHR edge.
REQ-012 ser_out_l  output  1  meaning bit shifted out at MSB; registered copy of q[WIDTH-1] taken before the SHL edge.
REQ-013 shift_cnt  output  clog2(WIDTH+1)  meaning shifts performed since last LOAD or reset, saturating at WIDTH.
REQ-014 word_done  output  1  meaning one-cycle pulse when shift_cnt reaches WIDTH.

Function
REQ-015 With en=1 and mode=HOLD, or with en=0, the block SHALL leave q, ser_out_r, ser_out_l and shift_cnt unchanged; word_done SHALL be 0.
REQ-016 With en=1 and mode=SHR, the block SHALL set q <= {ser_in_r, q[WIDTH-1:1]} and ser_out_r <= q[0]; ser_out_l SHALL be unchanged.
REQ-017 With en=1 and mode=SHL, the block SHALL set q <= {q[WIDTH-2:0], ser_in_l} and ser_out_l <= q[WIDTH-1]; ser_out_r SHALL be unchanged.
REQ-018 With en=1 and mode=LOAD, the block SHALL set q <= par_in and shift_cnt <= 0; ser_out_r and ser_out_l SHALL be unchanged.
REQ-019 par_out SHALL equal q with zero combinational path from any input.
REQ-020 The latency from an input being sampled to its first appearance at a serial output SHALL be WIDTH+1 edges, for both SHR and SHL.
REQ-021 Each SHR or SHL with shift_cnt<WIDTH SHALL increment shift_cnt by 1; at WIDTH the count SHALL saturate.
REQ-022 word_done SHALL be asserted for exactly the cycle after the shift that moves shift_cnt from WIDTH-1 to WIDTH.
REQ-023 Further shifts at saturation SHALL NOT re-assert word_done until a LOAD or reset occurs.
REQ-024 Mixed SHR/SHL shifts SHALL each count as one shift.
REQ-025 A LOAD on the same edge that would have completed a word SHALL take priority: shift_cnt <= 0 and word_done <= 0.

Reset
REQ-026 On rst=1 at a rising edge, the block SHALL set q <= RESET_VAL, ser_out_r <= 0, ser_out_l <= 0, shift_cnt <= 0 and word_done <= 0, regardless of en and mode.
REQ-027 Reset asserted mid-word SHALL abandon the word, and no word_done SHALL follow.
REQ-028 The first operation after reset SHALL be honoured on the first edge with rst=0.

Structure
REQ-029 The mode encodings HOLD, SHR, SHL and LOAD SHALL be defined as constants in shared package shift_reg_pkg; no other typedefs are required.
REQ-030 The saturating shift counter with its word_done pulse SHALL be a sub-module named shift_word_counter, parameterised by WIDTH, with inputs clk, rst, clear and step.
REQ-031 The data path SHALL be a single always block in param_shift_register.

Verification
REQ-032 SISO regression: WIDTH=4, mode=SHR held, ser_in_r stream 1,0,1,1 -> ser_out_r shows 1,0,1,1 starting on edge 5.
REQ-033 Load then shift: LOAD 8'hA5, then 8x SHR with ser_in_r=0 -> ser_out_r sequence 1,0,1,0,0,1,0,1; word_done pulses once, after the 8th shift; par_out=8'h00.
REQ-034 SHL and enable: LOAD 8'h81, 3x SHL with ser_in_l=1 and en toggled 1,0,1,1 -> exactly 3 shifts occur; par_out=8'h0F; shift_cnt=3.
REQ-035 Collision: after 7 shifts, apply LOAD 8'h3C on the 8th cycle -> word_done stays 0; shift_cnt=0; par_out=8'h3C.
REQ-036 Reset mid-word: 5 shifts, then rst=1 for one cycle -> all outputs return to reset values; a further 8 shifts produce a single word_done.
REQ-037 Saturation: 12 consecutive SHR after LOAD -> shift_cnt holds at 8 and word_done is high for exactly one cycle.
